// File: rtl/wb_efb_arbiter_if.sv
// Wishbone classic bus bundle between wb_efb_arbiter (master) and the EFB slave port.
interface wb_efb_arbiter_if;
  logic       o_wb_cyc;
  logic       o_wb_stb;
  logic       o_wb_we;
  logic [7:0] o_wb_adr;
  logic [7:0] o_wb_dat;
  logic [7:0] i_wb_dat;
  logic       i_wb_ack;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
    input  i_wb_dat, i_wb_ack
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
    output i_wb_dat, i_wb_ack
  );
endinterface

// File: rtl/wb_efb_arbiter.sv
// Shares the EFB Wishbone slave port between NUM_REQ requesters, one classic cycle at a time.
// Define WB_EFB_ARB_PRIORITY_EN for fixed lowest-index priority instead of round robin.
module wb_efb_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic [NUM_REQ-1:0]     i_Req,
  input  logic [NUM_REQ-1:0]     i_We,
  input  logic [8*NUM_REQ-1:0]   i_Addr,
  input  logic [8*NUM_REQ-1:0]   i_WrData,
  output logic [NUM_REQ-1:0]     o_Done,
  output logic                   o_Err,
  output logic [7:0]             o_RdData,
  output logic                   o_Busy,
  wb_efb_arbiter_if.master       wb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [7:0]         adr_q, adr_d;
  logic [7:0]         dat_q, dat_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         rd_q, rd_d;
  logic               busy_q, busy_d;

  logic [7:0]         addr_a [NUM_REQ];
  logic [7:0]         wdat_a [NUM_REQ];
  logic               sel_found_s;
  logic [PTR_W-1:0]   sel_idx_s;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_a[k] = i_Addr[8*k +: 8];
      wdat_a[k] = i_WrData[8*k +: 8];
    end
  end

  // Scan from the far end back toward the start so the last hit is the nearest candidate.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef WB_EFB_ARB_PRIORITY_EN
      if (i_Req[k]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PTR_W'(k);
      end else begin
        sel_found_s = sel_found_s;
      end
`else
      if (i_Req[rr_idx(ptr_q, k)]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = rr_idx(ptr_q, k);
      end else begin
        sel_found_s = sel_found_s;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = done_q;
    err_d   = err_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          win_d   = sel_idx_s;
          we_d    = i_We[sel_idx_s];
          adr_d   = addr_a[sel_idx_s];
          dat_d   = wdat_a[sel_idx_s];
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Ack is tested first so a last-cycle ack still completes cleanly.
        if (wb.i_wb_ack || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = ~wb.i_wb_ack;
          if (wb.i_wb_ack && !we_q) begin
            rd_d = wb.i_wb_dat;
          end else begin
            rd_d = rd_q;
          end
          for (int k = 0; k < NUM_REQ; k++) begin
            done_d[k] = (win_q == PTR_W'(k));
          end
`ifndef WB_EFB_ARB_PRIORITY_EN
          if (win_q == PTR_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_q + PTR_W'(1);
          end
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset drops the bus asynchronously.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 8'h00;
      dat_q   <= 8'h00;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Done      = done_q;
  assign o_Err       = err_q;
  assign o_RdData    = rd_q;
  assign o_Busy      = busy_q;
  assign wb.o_wb_cyc = cyc_q;
  assign wb.o_wb_stb = stb_q;
  assign wb.o_wb_we  = we_q;
  assign wb.o_wb_adr = adr_q;
  assign wb.o_wb_dat = dat_q;

endmodule
